// File: rtl/axis_pkt_fifo.sv
// AXI-Stream packet FIFO: circular word buffer with cut-through or store-and-forward
// release, plus a packet-length cap that forces tlast and marks the split on tuser.
module axis_pkt_fifo #(
    parameter int unsigned C_AXIS_DATA_WIDTH = 32,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned MAX_PKT_WORDS     = 8,
    parameter int unsigned STORE_FWD         = 1
) (
    input  logic                             s_axis_aclk,
    input  logic                             s_axis_areset,
    output logic                             s_axis_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                             s_axis_tlast,
    input  logic                             s_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tuser,
    output logic                             m_axis_tvalid,
    output logic [$clog2(DEPTH):0]           word_count,
    output logic [$clog2(DEPTH):0]           pkt_count
);

    localparam int unsigned DATA_W = C_AXIS_DATA_WIDTH;
    localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned SEG_W  = (MAX_PKT_WORDS > 1) ? $clog2(MAX_PKT_WORDS) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic              forced;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             wr_entry;
    entry_t             rd_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [SEG_W-1:0]   seg_cnt;
    logic               full;
    logic               empty;
    logic               seg_cap;
    logic               wr_en;
    logic               rd_en;

    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign s_axis_tready = !full && !s_axis_areset;
    assign wr_en         = s_axis_tvalid && s_axis_tready;

    // Last slot of a maximum-length segment: split here unless the source ends the packet.
    always_comb begin
        seg_cap         = (seg_cnt == SEG_W'(MAX_PKT_WORDS - 1));
        wr_entry.data   = s_axis_tdata;
        wr_entry.strb   = s_axis_tstrb;
        wr_entry.last   = s_axis_tlast | seg_cap;
        wr_entry.forced = seg_cap & ~s_axis_tlast;
    end

    assign rd_entry      = mem[rd_ptr[ADDR_W-1:0]];
    assign m_axis_tdata  = rd_entry.data;
    assign m_axis_tstrb  = rd_entry.strb;
    assign m_axis_tlast  = rd_entry.last;
    assign m_axis_tuser  = rd_entry.forced;
    assign m_axis_tvalid = !empty && ((STORE_FWD == 0) || (pkt_count != '0));
    assign rd_en         = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_entry;
        end
    end

    // Pointers, segment length and occupancy counters move together on each edge.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            seg_cnt    <= '0;
            word_count <= '0;
            pkt_count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr  <= wr_ptr + PTR_W'(1);
                seg_cnt <= wr_entry.last ? '0 : seg_cnt + SEG_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            word_count <= word_count + PTR_W'(wr_en) - PTR_W'(rd_en);
            pkt_count  <= pkt_count + PTR_W'(wr_en & wr_entry.last)
                                    - PTR_W'(rd_en & rd_entry.last);
        end
    end

endmodule
